// File: rtl/pun_emisor_pkg.sv
// Shared definitions for the score-message interface (emitter and ranking tracker).
package pun_emisor_pkg;

   localparam int unsigned MENS_BITS_DEF = 4;
   localparam int unsigned PUN_BITS_DEF  = 7;

   localparam logic [3:0] PUN  = 4'b1000;
   localparam logic [3:0] NONE = 4'b0000;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StSend = 2'd2
   } pun_state_e;

endpackage

// File: rtl/pun_tick_gen.sv
// Prescaler: asserts tick for one cycle every TICK_DIV enabled cycles. clr has priority over en.
module pun_tick_gen #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned    CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pun_emisor.sv
// Round timer that reports its score as one valid/ready message at round end.
// Optional penalty input is enabled by defining PUN_PENALTY_EN.
module pun_emisor
   import pun_emisor_pkg::*;
#(
   parameter int unsigned MENS_BITS = MENS_BITS_DEF,
   parameter int unsigned PUN_BITS  = PUN_BITS_DEF,
`ifdef PUN_PENALTY_EN
   parameter int unsigned PEN_VAL   = 5,
`endif
   parameter int unsigned TICK_DIV  = 50_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 abort,
`ifdef PUN_PENALTY_EN
   input  logic                 penalty,
`endif
   input  logic                 msg_ready,
   output logic                 msg_valid,
   output logic [MENS_BITS-1:0] msg_data,
   output logic [PUN_BITS-1:0]  msg_pun,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned MaxScore = (1 << PUN_BITS) - 1;

   pun_state_e          state_q, state_d;
   logic [PUN_BITS-1:0] score_q, score_d;
   logic [PUN_BITS-1:0] pun_q, pun_d;
   logic [PUN_BITS-1:0] score_sat;
   logic [31:0]         inc, sum;
   logic                tick, clr;

   pun_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (state_q == StRun),
      .tick (tick)
   );

   // Tick and penalty are summed first so saturation applies once on the total.
   always_comb begin
      inc = tick ? 32'd1 : 32'd0;
`ifdef PUN_PENALTY_EN
      if (penalty) begin
         inc = inc + PEN_VAL;
      end
`endif
      sum       = 32'(score_q) + inc;
      score_sat = (sum > MaxScore) ? PUN_BITS'(MaxScore) : PUN_BITS'(sum);
   end

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      pun_d   = pun_q;
      clr     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               score_d = '0;
               clr     = 1'b1;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
               score_d = '0;
               clr     = 1'b1;
            end else if (start) begin
               score_d = '0;
               clr     = 1'b1;
            end else if (stop) begin
               state_d = StSend;
               score_d = score_sat;
               pun_d   = score_sat;
            end else begin
               score_d = score_sat;
            end
         end
         StSend: begin
            if (msg_ready) begin
               state_d = StIdle;
               pun_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         score_q <= '0;
         pun_q   <= '0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         pun_q   <= pun_d;
      end
   end

   assign msg_valid = (state_q == StSend);
   assign msg_data  = (state_q == StSend) ? MENS_BITS'(PUN) : MENS_BITS'(NONE);
   assign msg_pun   = pun_q;
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StSend) && msg_ready;

endmodule

// File: tb/tb_pun_emisor.sv
// Scoreboard bench for pun_emisor with TICK_DIV=4; penalty case only when PUN_PENALTY_EN is defined.
module tb_pun_emisor;

   localparam int unsigned TickDiv = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, stop = 1'b0, abort = 1'b0, msg_ready = 1'b0;
`ifdef PUN_PENALTY_EN
   logic       penalty = 1'b0;
`endif
   logic       msg_valid, busy, done;
   logic [3:0] msg_data;
   logic [6:0] msg_pun;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   pun_emisor #(
      .MENS_BITS (4),
      .PUN_BITS  (7),
`ifdef PUN_PENALTY_EN
      .PEN_VAL   (5),
`endif
      .TICK_DIV  (TickDiv)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .abort     (abort),
`ifdef PUN_PENALTY_EN
      .penalty   (penalty),
`endif
      .msg_ready (msg_ready),
      .msg_valid (msg_valid),
      .msg_data  (msg_data),
      .msg_pun   (msg_pun),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      check({name, ".valid"}, int'(msg_valid), 0);
      check({name, ".data"}, int'(msg_data), 0);
      check({name, ".pun"}, int'(msg_pun), 0);
      check({name, ".busy"}, int'(busy), 0);
      check({name, ".done"}, int'(done), 0);
   endtask

   // Leaves the bench in the first RUN cycle (C1).
   task automatic start_round();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   // Monitor: pops an expected score on every accepted transfer.
   always @(negedge clk) begin
      if (!rst && msg_valid && msg_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_msg", 1, 0);
         end else begin
            int e;
            e = exp_q.pop_front();
            check("xfer.pun", int'(msg_pun), e);
            check("xfer.data", int'(msg_data), 8);
            check("xfer.done", int'(done), 1);
         end
      end else if (msg_valid && !msg_ready) begin
         check("stall.done", int'(done), 0);
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step(2);
      check_idle("reset");
      rst = 1'b0;
      step(1);

      // Basic round: stop in cycle 52 after start -> 13 ticks
      msg_ready = 1'b1;
      start_round();
      @(negedge clk);
      check("basic.busy_run", int'(busy), 1);
      step(51);
      stop = 1'b1;
      exp_q.push_back(13);
      step(1);
      stop = 1'b0;
      @(negedge clk);
      check("basic.valid", int'(msg_valid), 1);
      step(1);
      check_idle("basic.after");

      // Back-pressure: score 5, held 10 cycles; control pulses ignored in SEND
      msg_ready = 1'b0;
      start_round();
      step(19);
      stop = 1'b1;
      exp_q.push_back(5);
      step(1);
      stop = 1'b0;
      for (int i = 0; i < 10; i++) begin
         abort = (i == 2);
         start = (i == 4);
         stop  = (i == 6);
         @(negedge clk);
         check("bp.valid", int'(msg_valid), 1);
         check("bp.data", int'(msg_data), 8);
         check("bp.pun", int'(msg_pun), 5);
         check("bp.busy", int'(busy), 1);
         step(1);
      end
      abort = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      msg_ready = 1'b1;
      step(1);
      check_idle("bp.after");

      // Saturation: 130 ticks -> 127
      start_round();
      step(519);
      stop = 1'b1;
      exp_q.push_back(127);
      step(1);
      stop = 1'b0;
      step(1);
      check_idle("sat.after");

      // Abort and stop together: no message
      start_round();
      step(10);
      abort = 1'b1;
      stop  = 1'b1;
      step(1);
      abort = 1'b0;
      stop  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_idle("abort");
         step(1);
      end

      // Restart in RUN at cycle 10 (score 2), then 4 ticks -> 4
      start_round();
      step(9);
      start_round();
      step(15);
      stop = 1'b1;
      exp_q.push_back(4);
      step(1);
      stop = 1'b0;
      step(1);
      check_idle("restart.after");

      // Reset mid-SEND drops the message
      msg_ready = 1'b0;
      start_round();
      step(7);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      @(negedge clk);
      check("rst_send.valid", int'(msg_valid), 1);
      check("rst_send.pun", int'(msg_pun), 2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      msg_ready = 1'b1;
      check_idle("rst_send.after");
      step(1);
      check_idle("rst_send.later");

`ifdef PUN_PENALTY_EN
      // 3 ticks + 2 penalties of 5 -> 13; penalty in IDLE ignored
      penalty = 1'b1;
      step(1);
      penalty = 1'b0;
      start_round();
      step(1);
      penalty = 1'b1;
      step(1);
      penalty = 1'b0;
      step(2);
      penalty = 1'b1;
      step(1);
      penalty = 1'b0;
      step(6);
      stop = 1'b1;
      exp_q.push_back(13);
      step(1);
      stop = 1'b0;
      step(1);
      check_idle("pen.after");
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pun_emisor.md
Name: pun_emisor

Overview:
- Producer end of the score-message interface; the ranking tracker sits downstream and consumes the messages.
- Times one game round in score units: one unit per TICK_DIV clock cycles.
- At round end, emits a single score message: msg_data = PUN code with msg_pun = the round score.
- Message transfer uses a valid/ready handshake so the ranking stage can stall.

Parameters:
- MENS_BITS, 4, width of the message-code bus.
- PUN_BITS, 7, width of the score bus; score saturates at 2^PUN_BITS-1 (127).
- TICK_DIV, 50_000_000, clock cycles per score unit; must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a round
- stop  in  1  one-cycle pulse; round completed, report the score
- abort  in  1  one-cycle pulse; cancel the round, no message
- msg_ready  in  1  downstream accepts the message
- msg_valid  out  1  message present
- msg_data  out  MENS_BITS  message code; PUN (4'b1000) while valid, NONE (4'b0000) otherwise
- msg_pun  out  PUN_BITS  score carried by the message; 0 when not valid
- busy  out  1  high in RUN or SEND
- done  out  1  one-cycle pulse on the accepted transfer

Behaviour:
- Reset values:
  - All outputs 0; msg_data = NONE.
  - State IDLE; score counter and prescaler 0.
  - rst has priority over every input, in every state, including mid-handshake. A pending message is dropped.
- States:
  - IDLE: start -> RUN next cycle. Score and prescaler clear to 0 on that edge. stop and abort are ignored.
  - RUN: busy=1. The prescaler counts 0..TICK_DIV-1; on wrap it asserts tick for one cycle and score increments.
    - The score saturates at all-ones and never wraps.
    - stop -> SEND. The value captured into msg_pun includes any tick in the same cycle.
    - abort -> IDLE, no message; score cleared.
    - abort and stop in the same cycle: abort wins.
    - start in RUN restarts the round: score and prescaler cleared, stay in RUN.
  - SEND: msg_valid=1, msg_data=PUN, msg_pun held stable until accepted.
    - On the first cycle with msg_ready=1: transfer completes, done=1 that cycle, next state IDLE.
    - msg_ready already high on SEND entry: transfer completes in the first SEND cycle (latency stop->valid = 1 cycle).
    - start, stop and abort are ignored in SEND; a message cannot be withdrawn.
- Outputs are registered and glitch-free: msg_valid, msg_data, msg_pun and busy come from state or registers only.
- msg_valid must not depend combinationally on msg_ready.
- Width rules: score is PUN_BITS wide unsigned. The prescaler is $clog2(TICK_DIV) bits and compares against TICK_DIV-1.

Optional Feature:
- Macro: PUN_PENALTY_EN.
- Defined:
  - Adds input penalty (1 bit, one-cycle pulse) and parameter PEN_VAL (default 5).
  - In RUN, a penalty pulse adds PEN_VAL to score, saturating at all-ones.
  - Penalty and tick in the same cycle: both are added, saturating once on the total.
  - Penalty outside RUN is ignored.
- Undefined: no port, no parameter, no penalty logic; behaviour exactly as above.

Decomposition:
- Shared package holds:
  - message-code constants PUN = 4'b1000 and NONE = 4'b0000;
  - the MENS_BITS/PUN_BITS defaults;
  - the state encoding (IDLE, RUN, SEND).
- The ranking tracker imports the same package so both ends agree on codes.
- Sub-module pun_tick_gen: prescaler with inputs clk, rst, clr, en and output tick. It is reusable for other timed blocks.

Test Plan:
- Basic round (TICK_DIV=4, msg_ready=1): start, then stop 4*13 cycles later -> msg_valid one cycle after stop, msg_data=4'b1000, msg_pun=13, done same cycle, busy drops next cycle.
- Back-pressure: msg_ready=0 for 10 cycles after stop -> msg_valid, msg_data and msg_pun stable all 10 cycles; done only on the cycle msg_ready rises.
- Saturation (TICK_DIV=2): run 300 cycles, then stop -> msg_pun=127, no wrap to 0.
- Abort and collisions: abort+stop in the same RUN cycle -> IDLE, msg_valid never asserted. start during RUN -> score restarts from 0.
- Reset mid-SEND: rst while msg_valid=1 -> next cycle all outputs 0, msg_data=4'b0000, state IDLE.
- PUN_PENALTY_EN (TICK_DIV=4, PEN_VAL=5): 3 ticks plus 2 penalties, then stop -> msg_pun=13.
